// File: rtl/cpu_pkg.sv
// Shared CPU types and fetch-stage defaults: state encoding, word type,
// reset vector, sequential PC step and the NOP used for bubbles.
package cpu_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t RESET_VECTOR_DEF = 32'h0000_0000;
   localparam word_t PC_STEP_DEF      = 32'd4;
   localparam word_t NOP_INSTR_DEF    = 32'hE1A0_0000;

   // Branch targets are word-aligned by clearing the two byte-offset bits.
   function automatic word_t word_align(input word_t addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: load has priority over increment, otherwise
// holds; asynchronous active-low reset to the reset vector.
module pc_reg
   import cpu_pkg::*;
#(
   parameter word_t RESET_VECTOR = RESET_VECTOR_DEF,
   parameter word_t PC_STEP      = PC_STEP_DEF
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_en,
   input  word_t load_val,
   input  logic  inc_en,
   output word_t pc_q
);

   word_t pc_r;

   // PC update; the add wraps modulo 2^32 by construction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_VECTOR;
      end else if (load_en) begin
         pc_r <= load_val;
      end else if (inc_en) begin
         pc_r <= pc_r + PC_STEP;
      end else begin
         pc_r <= pc_r;
      end
   end

   assign pc_q = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC/FSM control plus IF/ID register.
// Optional performance counters are enabled with macro FETCH_PERF_CNT_EN.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter word_t RESET_VECTOR = RESET_VECTOR_DEF,
   parameter word_t PC_STEP      = PC_STEP_DEF,
   parameter word_t NOP_INSTR    = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        halt_i,
   output logic [31:0] PC_Out,
   input  logic [31:0] theInstruction,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic        valid_d,
   output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] squash_cnt_o
`endif
);

   fetch_state_t state_r;
   fetch_state_t next_state_s;

   word_t pc_q_s;
   word_t pc_load_val_s;
   logic  pc_load_s;
   logic  pc_inc_s;

   word_t instr_r;
   word_t pc_d_r;
   logic  valid_r;
   logic  halted_r;

   word_t instr_nxt_s;
   word_t pc_d_nxt_s;
   logic  valid_nxt_s;
   logic  fetch_inc_s;
   logic  squash_inc_s;

   pc_reg #(
      .RESET_VECTOR (RESET_VECTOR),
      .PC_STEP      (PC_STEP)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (pc_load_s),
      .load_val (pc_load_val_s),
      .inc_en   (pc_inc_s),
      .pc_q     (pc_q_s)
   );

   assign PC_Out = pc_q_s;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= BOOT;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state, PC controls and IF/ID next values; priority halt > branch > stall.
   always_comb begin
      next_state_s  = state_r;
      pc_load_s     = 1'b0;
      pc_inc_s      = 1'b0;
      pc_load_val_s = word_align(branch_target_i);
      instr_nxt_s   = instr_r;
      pc_d_nxt_s    = pc_d_r;
      valid_nxt_s   = valid_r;
      fetch_inc_s   = 1'b0;
      squash_inc_s  = 1'b0;
      case (state_r)
         BOOT: begin
            next_state_s = RUN;
            valid_nxt_s  = 1'b0;
         end
         RUN: begin
            if (halt_i) begin
               next_state_s = HALTED;
               valid_nxt_s  = 1'b0;
               instr_nxt_s  = NOP_INSTR;
            end else if (branch_taken_i) begin
               pc_load_s    = 1'b1;
               instr_nxt_s  = NOP_INSTR;
               pc_d_nxt_s   = 32'h0000_0000;
               valid_nxt_s  = 1'b0;
               squash_inc_s = 1'b1;
            end else if (stall_i) begin
               next_state_s = RUN;
            end else begin
               instr_nxt_s = theInstruction;
               pc_d_nxt_s  = pc_q_s;
               valid_nxt_s = 1'b1;
               pc_inc_s    = 1'b1;
               fetch_inc_s = 1'b1;
            end
         end
         HALTED: begin
            next_state_s = HALTED;
            valid_nxt_s  = 1'b0;
         end
         default: begin
            next_state_s = BOOT;
            valid_nxt_s  = 1'b0;
            instr_nxt_s  = NOP_INSTR;
         end
      endcase
   end

   // IF/ID register and halted flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_r  <= NOP_INSTR;
         pc_d_r   <= 32'h0000_0000;
         valid_r  <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         instr_r  <= instr_nxt_s;
         pc_d_r   <= pc_d_nxt_s;
         valid_r  <= valid_nxt_s;
         halted_r <= (next_state_s == HALTED);
      end
   end

   assign instr_d  = instr_r;
   assign pc_d     = pc_d_r;
   assign valid_d  = valid_r;
   assign halted_o = halted_r;

`ifdef FETCH_PERF_CNT_EN
   word_t fetch_cnt_r;
   word_t squash_cnt_r;

   // Counters only step from RUN, so they hold naturally in HALTED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_r  <= 32'h0000_0000;
         squash_cnt_r <= 32'h0000_0000;
      end else begin
         fetch_cnt_r  <= fetch_cnt_r + {31'd0, fetch_inc_s};
         squash_cnt_r <= squash_cnt_r + {31'd0, squash_inc_s};
      end
   end

   assign fetch_cnt_o  = fetch_cnt_r;
   assign squash_cnt_o = squash_cnt_r;
`endif

endmodule
